floor_request_latch: RTL and testbench

//   Parametrised successor to the combinational floor decoder.

---
 rtl/floor_request_latch.sv | 92 +++++++++
 tb/tb_floor_request_latch.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/floor_request_latch.sv
// floor_request_latch: decodes floor codes to one-hot, keeps a mask of pending
// hall/car requests, clears a floor when the car arrives there, and derives
// above/below/here flags for the elevator direction logic.
module floor_request_latch #(
  parameter int FLOORS = 8,
  parameter int CODE_W = 4,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [CODE_W-1:0] req_floor,
  input  logic [CODE_W-1:0] cur_floor,
  input  logic              arrive,
  input  logic              clr_all,
  output logic [FLOORS-1:0] pending,
  output logic [FLOORS-1:0] cur_onehot,
  output logic              req_above,
  output logic              req_below,
  output logic              req_here,
  output logic [CNT_W-1:0]  pend_cnt,
  output logic              req_err
);

  // Per-floor decode: bit i matches code i+1, so codes 0 and >FLOORS give all zero.
  logic [FLOORS-1:0] req_dec, cur_dec;

  for (genvar i = 0; i < FLOORS; i++) begin : g_dec
    assign req_dec[i] = (req_floor == CODE_W'(i + 1));
    assign cur_dec[i] = (cur_floor == CODE_W'(i + 1));
  end

  // A code is valid exactly when its decode has a bit set.
  logic req_ok;
  assign req_ok = |req_dec;

  logic [FLOORS-1:0] pending_q, pending_d;
  logic [FLOORS-1:0] cur_oh_q, cur_oh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic [FLOORS-1:0] set_mask, clr_mask;

  // Next pending mask: flush wins, then the arrival clear beats a same-floor set.
  always_comb begin
    set_mask  = (req_valid && req_ok) ? req_dec : '0;
    clr_mask  = arrive ? cur_dec : '0;
    pending_d = (pending_q | set_mask) & ~clr_mask;
    if (clr_all) pending_d = '0;
    cur_oh_d  = cur_dec;
    err_d     = req_valid & ~req_ok;
  end

  // Count tracks the next mask so it lines up with the registered pending.
  always_comb begin
    cnt_d = '0;
    for (int i = 0; i < FLOORS; i++) cnt_d = cnt_d + CNT_W'(pending_d[i]);
  end

  // State registers; async reset drops every request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= '0;
      cur_oh_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      cur_oh_q  <= cur_oh_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
    end
  end

  // Direction flags from registered state. cur_oh_q - 1 is all ones when the
  // position is invalid, so every flag is gated by a valid position.
  logic [FLOORS-1:0] below_mask;
  logic              pos_ok;

  always_comb begin
    pos_ok     = |cur_oh_q;
    below_mask = cur_oh_q - FLOORS'(1);
    req_here   = |(pending_q & cur_oh_q);
    req_above  = pos_ok & (|(pending_q & ~(cur_oh_q | below_mask)));
    req_below  = pos_ok & (|(pending_q & below_mask));
  end

  assign pending    = pending_q;
  assign cur_onehot = cur_oh_q;
  assign pend_cnt   = cnt_q;
  assign req_err    = err_q;

endmodule

// File: tb/tb_floor_request_latch.sv
// Directed bench for floor_request_latch: reset, latching, arrival clear,
// same-cycle priority, invalid codes and full-mask count.
module tb_floor_request_latch;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic [3:0] req_floor;
  logic [3:0] cur_floor;
  logic       arrive;
  logic       clr_all;
  logic [7:0] pending;
  logic [7:0] cur_onehot;
  logic       req_above, req_below, req_here;
  logic [3:0] pend_cnt;
  logic       req_err;

  int checks = 0;
  int errors = 0;

  floor_request_latch #(.FLOORS(8), .CODE_W(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_floor(req_floor),
    .cur_floor(cur_floor), .arrive(arrive), .clr_all(clr_all),
    .pending(pending), .cur_onehot(cur_onehot), .req_above(req_above),
    .req_below(req_below), .req_here(req_here), .pend_cnt(pend_cnt),
    .req_err(req_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one edge; inputs change and outputs are sampled 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_req(input logic [3:0] code);
    req_valid = 1'b1;
    req_floor = code;
    step();
    req_valid = 1'b0;
  endtask

  task automatic do_clr();
    clr_all = 1'b1;
    step();
    clr_all = 1'b0;
  endtask

  task automatic chk_flags(input string tag, input logic a, input logic b, input logic h);
    chk({tag, "_above"}, req_above, a);
    chk({tag, "_below"}, req_below, b);
    chk({tag, "_here"},  req_here,  h);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_floor = '0; cur_floor = '0;
    arrive = 1'b0; clr_all = 1'b0;
    step(); step();
    chk("rst_pending", pending, 8'h00);
    chk("rst_cur", cur_onehot, 8'h00);
    chk("rst_cnt", pend_cnt, 4'd0);
    chk("rst_err", req_err, 1'b0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // 1: build 8'hA5 (floors 1,3,6,8), then async reset mid-cycle
    do_req(4'd1); do_req(4'd3); do_req(4'd6); do_req(4'd8);
    chk("t1_pending", pending, 8'hA5);
    chk("t1_cnt", pend_cnt, 4'd4);
    #2 rst = 1'b1;
    #1;
    chk("t1_async_pending", pending, 8'h00);
    chk("t1_async_cnt", pend_cnt, 4'd0);
    step();
    rst = 1'b0;
    do_req(4'd2);
    chk("t1_after_pending", pending, 8'h02);
    chk("t1_after_cnt", pend_cnt, 4'd1);
    do_clr();
    chk("clr_pending", pending, 8'h00);

    // 2: cur=3, requests 5 and 1
    cur_floor = 4'd3;
    do_req(4'd5); do_req(4'd1);
    chk("t2_cur", cur_onehot, 8'h04);
    chk("t2_pending", pending, 8'h11);
    chk("t2_cnt", pend_cnt, 4'd2);
    chk_flags("t2", 1'b1, 1'b1, 1'b0);
    do_clr();

    // 3: pending at 5, car arrives at 5
    do_req(4'd5);
    cur_floor = 4'd5;
    step();
    chk_flags("t3_pre", 1'b0, 1'b0, 1'b1);
    arrive = 1'b1; step(); arrive = 1'b0;
    chk("t3_pending", pending, 8'h00);
    chk("t3_cnt", pend_cnt, 4'd0);
    chk_flags("t3", 1'b0, 1'b0, 1'b0);

    // 4: arrival clear beats same-floor set; different floors both act
    cur_floor = 4'd4;
    step();
    arrive = 1'b1; do_req(4'd4); arrive = 1'b0;
    chk("t4_same", pending, 8'h00);
    do_req(4'd4);
    chk("t4_set4", pending, 8'h08);
    arrive = 1'b1; do_req(4'd6); arrive = 1'b0;
    chk("t4_diff", pending, 8'h20);
    chk("t4_cnt", pend_cnt, 4'd1);
    chk_flags("t4", 1'b1, 1'b0, 1'b0);
    do_clr();

    // 5: invalid request codes and invalid position
    do_req(4'd2);
    do_req(4'd0);
    chk("t5_err0", req_err, 1'b1);
    chk("t5_pend0", pending, 8'h02);
    step();
    chk("t5_err_pulse", req_err, 1'b0);
    do_req(4'd9);
    chk("t5_err9", req_err, 1'b1);
    chk("t5_pend9", pending, 8'h02);
    do_req(4'd15);
    chk("t5_err15", req_err, 1'b1);
    chk("t5_pend15", pending, 8'h02);
    chk("t5_cnt", pend_cnt, 4'd1);
    cur_floor = 4'd0;
    step();
    chk("t5_err_low", req_err, 1'b0);
    chk("t5_cur0", cur_onehot, 8'h00);
    chk_flags("t5", 1'b0, 1'b0, 1'b0);

    // 6: full mask, then flush with same-cycle requests
    for (int k = 1; k <= 8; k++) do_req(4'(k));
    chk("t6_full", pending, 8'hFF);
    chk("t6_cnt8", pend_cnt, 4'd8);
    do_req(4'd8);
    chk("t6_repeat", pending, 8'hFF);
    chk("t6_repeat_cnt", pend_cnt, 4'd8);
    clr_all = 1'b1; do_req(4'd2); clr_all = 1'b0;
    chk("t6_clr_pending", pending, 8'h00);
    chk("t6_clr_cnt", pend_cnt, 4'd0);
    chk("t6_clr_noerr", req_err, 1'b0);
    clr_all = 1'b1; do_req(4'd9); clr_all = 1'b0;
    chk("t6_clr_err", req_err, 1'b1);
    chk("t6_clr_pending2", pending, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
